vme_mem_master: RTL and testbench
=================================

Name: vme_mem_master

Overview:
- Initiator (bus master) for the VMEAddr/VMERdMem/VMEWrMem register-bank interface that our generated register banks respond to.
- Accepts single read/write commands on a valid/ready command port and issues one single-cycle strobe per command.
- Waits for Done/Error from the register bank, with a timeout, then returns read data and a status on a valid/ready response port.
- Sits between a local controller (sequencer, test harness, bridge) and one register bank.

Parameters:
- ADDR_HI, 19, MSB of word address; address bus is [ADDR_HI:2].
- DATA_W, 32, data width of VMERdData/VMEWrData and cmd/rsp data.
- TIMEOUT, 255, cycles waited after the strobe before a timeout is declared; must be ≥2.
- TO_W, 8, width of the timeout counter; must satisfy 2**TO_W > TIMEOUT.

Ports:
- Clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  master can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_HI-1  word address [ADDR_HI:2]
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  DATA_W  read data; 0 for writes, errors and timeouts
- rsp_status  out  2  00 OK, 01 bus error, 10 timeout
- busy  out  1  high in every state except IDLE
- VMEAddr  out  ADDR_HI-1  address to the bank
- VMEWrData  out  DATA_W  write data to the bank
- VMERdMem  out  1  one-cycle read strobe
- VMEWrMem  out  1  one-cycle write strobe
- VMERdData  in  DATA_W  read data from the bank
- VMERdDone, VMEWrDone  in  1  completion from the bank
- VMERdError, VMEWrError  in  1  error completion from the bank

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; all outputs 0 except cmd_ready=1. This includes VMEAddr, VMEWrData, strobes, rsp_*, busy and the counter.
- Reset mid-transaction aborts the transaction. No response is generated, and a later Done from the bank is ignored.
- All outputs are registered.
- FSM states: IDLE, STROBE, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch cmd_addr into VMEAddr; latch cmd_wdata into VMEWrData (write only); latch the write flag; go to STROBE.
- STROBE (exactly 1 cycle):
  - VMERdMem=1 for a read, or VMEWrMem=1 for a write.
  - Clear the timeout counter; go to WAIT.
  - Done/Error inputs are not sampled in this cycle.
- WAIT:
  - Sample only the pair matching the direction (Rd* for reads, Wr* for writes).
  - Error=1 (takes precedence even when Done=1 in the same cycle): status 01, rdata 0.
  - Else Done=1: status 00; rdata = VMERdData sampled this cycle for reads, 0 for writes.
  - Else, if the counter equals TIMEOUT-1: status 10, rdata 0. Otherwise increment the counter.
  - On any of the three outcomes: set rsp_valid=1 and go to RESP.
- RESP:
  - Hold rsp_valid, rsp_rdata and rsp_status stable until rsp_ready=1.
  - On that cycle clear rsp_valid and go to IDLE.
- VMEAddr and VMEWrData stay stable from the IDLE→STROBE transition until the next command is accepted.
- Strobes are never asserted outside STROBE. There is at most one outstanding transaction.
- Done/Error arriving in IDLE or RESP (late, after a timeout) is ignored.
- Latency with a bank that acks a read 1 cycle after the strobe: command accepted at cycle t, strobe at t+1, Done at t+2, rsp_valid at t+3.
- Throughput: next cmd_ready no earlier than the cycle after the rsp handshake.

Decomposition:
- Shared package vme_master_pkg:
  - status constants ST_OK=2'b00, ST_BUSERR=2'b01, ST_TIMEOUT=2'b10;
  - FSM state encoding.
- One sub-module is natural: vme_timeout_cnt (clear, enable, terminal-count compare against TIMEOUT).
- The FSM and datapath stay in the top module.

Test Plan:
All cases run against the generated two-register bank: r1 8-bit at word 0, r2 16-bit at word 1.
1. Write then read: write addr 0 data 0x000000A5 → rsp status 00 and rdata 0. Then read addr 0 → rdata 0x000000A5, status 00, rsp_valid exactly 3 cycles after cmd handshake.
2. Write r2: write addr 1 data 0xFFFF1234, then read addr 1 → rdata 0x00001234; exactly one VMEWrMem pulse and one VMERdMem pulse are observed.
3. Timeout: TIMEOUT=8, slave Done/Error tied low, read addr 5 → status 10, rdata 0, rsp_valid on the 9th cycle after the strobe. A Done injected 2 cycles later is ignored, and the next command completes normally.
4. Bus error: slave drives VMEWrError and VMEWrDone together → status 01, rdata 0.
5. Backpressure: hold rsp_ready=0 for 10 cycles after a read → rsp_* stable, cmd_ready=0, no strobe issued. Release → next command accepted the cycle after the handshake.
6. Reset mid-WAIT: assert rst_n=0 asynchronously one cycle after the strobe → all outputs 0 and cmd_ready=1 immediately. The bank's subsequent Done produces no response.

Source files
------------

// File: rtl/vme_master_pkg.sv
// Shared definitions for the VME register-bank master: response status codes and FSM encoding.
package vme_master_pkg;
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BUSERR  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;
endpackage

// File: rtl/vme_timeout_cnt.sv
// Wait-cycle counter; tc flags the last cycle the master is allowed to wait for a completion.
module vme_timeout_cnt #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam logic [TO_W-1:0] TC_VAL = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == TC_VAL);
endmodule

// File: rtl/vme_mem_master.sv
// Single-outstanding initiator for the VMEAddr/VMERdMem/VMEWrMem register-bank interface.
module vme_mem_master
  import vme_master_pkg::*;
#(
  parameter int ADDR_HI = 19,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              Clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_HI:2]  cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_status,
  output logic              busy,
  output logic [ADDR_HI:2]  VMEAddr,
  output logic [DATA_W-1:0] VMEWrData,
  output logic              VMERdMem,
  output logic              VMEWrMem,
  input  logic [DATA_W-1:0] VMERdData,
  input  logic              VMERdDone,
  input  logic              VMEWrDone,
  input  logic              VMERdError,
  input  logic              VMEWrError
);
  state_t            state_q, state_d;
  logic              wr_q;
  logic              done, err, tc, cnt_clr, cnt_en, accept;
  logic              rd_mem_d, wr_mem_d, rsp_valid_d;
  logic [1:0]        rsp_status_d;
  logic [DATA_W-1:0] rsp_rdata_d;

  // Only the completion pair matching the latched direction is observed.
  assign done   = wr_q ? VMEWrDone  : VMERdDone;
  assign err    = wr_q ? VMEWrError : VMERdError;
  assign accept = (state_q == S_IDLE) && cmd_valid;

  vme_timeout_cnt #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_to (
    .clk  (Clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tc   (tc)
  );

  always_comb begin
    state_d      = state_q;
    rd_mem_d     = 1'b0;
    wr_mem_d     = 1'b0;
    rsp_valid_d  = rsp_valid;
    rsp_status_d = rsp_status;
    rsp_rdata_d  = rsp_rdata;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        state_d  = S_STROBE;
        rd_mem_d = !cmd_write;
        wr_mem_d = cmd_write;
      end
      S_STROBE: begin
        state_d = S_WAIT;
        cnt_clr = 1'b1;
      end
      S_WAIT: begin
        if (err) begin
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_BUSERR;
          rsp_rdata_d  = '0;
        end else if (done) begin
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_OK;
          rsp_rdata_d  = wr_q ? '0 : VMERdData;
        end else if (tc) begin
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_TIMEOUT;
          rsp_rdata_d  = '0;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_RESP: if (rsp_ready) begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_q       <= 1'b0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      VMERdMem   <= 1'b0;
      VMEWrMem   <= 1'b0;
      VMEAddr    <= '0;
      VMEWrData  <= '0;
      rsp_valid  <= 1'b0;
      rsp_status <= '0;
      rsp_rdata  <= '0;
    end else begin
      state_q    <= state_d;
      cmd_ready  <= (state_d == S_IDLE);
      busy       <= (state_d != S_IDLE);
      VMERdMem   <= rd_mem_d;
      VMEWrMem   <= wr_mem_d;
      rsp_valid  <= rsp_valid_d;
      rsp_status <= rsp_status_d;
      rsp_rdata  <= rsp_rdata_d;
      // Address/data hold until the next accepted command so the bank sees them stable.
      if (accept) begin
        VMEAddr <= cmd_addr;
        wr_q    <= cmd_write;
        if (cmd_write) VMEWrData <= cmd_wdata;
      end
    end
  end
endmodule

// File: tb/tb_vme_mem_master.sv
// Bench for vme_mem_master: two-register bank model plus transaction-level expectation model.
module tb_vme_mem_master;
  import vme_master_pkg::*;
  localparam int ADDR_HI = 19;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;
  localparam int TO_W    = 4;

  logic              Clk = 1'b0, rst_n = 1'b1;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_HI:2]  cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid, rsp_ready, busy;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_status;
  logic [ADDR_HI:2]  VMEAddr;
  logic [DATA_W-1:0] VMEWrData, VMERdData;
  logic              VMERdMem, VMEWrMem;
  logic              VMERdDone, VMEWrDone, VMERdError, VMEWrError;

  vme_mem_master #(.ADDR_HI(ADDR_HI), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .Clk(Clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .busy(busy), .VMEAddr(VMEAddr), .VMEWrData(VMEWrData), .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem),
    .VMERdData(VMERdData), .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone),
    .VMERdError(VMERdError), .VMEWrError(VMEWrError)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  // ---------------- register bank model (stimulus side) ----------------
  logic [7:0]  r1 = '0;
  logic [15:0] r2 = '0;
  int          b_mode = 0, b_lat = 1, b_cnt = 0;   // mode 0 normal, 1 silent, 2 error
  bit          noise = 0, inj_done = 0;
  logic        s_rd = 0, s_wr = 0, b_wr = 0;
  logic [ADDR_HI:2]  s_addr = '0, b_addr = '0;
  logic [DATA_W-1:0] s_wd = '0, b_wd = '0;
  int          n_rdp = 0, n_wrp = 0;

  always @(negedge Clk) begin
    s_rd = VMERdMem; s_wr = VMEWrMem; s_addr = VMEAddr; s_wd = VMEWrData;
    if (VMERdMem) n_rdp++;
    if (VMEWrMem) n_wrp++;
  end

  always @(posedge Clk) begin
    #1;
    VMERdDone = 0; VMEWrDone = 0; VMERdError = 0; VMEWrError = 0; VMERdData = '0;
    if (s_rd || s_wr) begin
      b_cnt = b_lat; b_wr = s_wr; b_addr = s_addr; b_wd = s_wd;
    end
    if (b_cnt > 0) begin
      b_cnt--;
      if (b_cnt == 0) begin
        if (b_mode == 2) begin
          if (b_wr) begin VMEWrError = 1; VMEWrDone = 1; end
          else begin VMERdError = 1; VMERdDone = 1; end
        end else if (b_mode == 0 && b_addr < 2) begin
          if (b_wr) begin
            if (b_addr == 0) r1 = b_wd[7:0]; else r2 = b_wd[15:0];
            VMEWrDone = 1;
          end else begin
            VMERdData = (b_addr == 0) ? {24'h0, r1} : {16'h0, r2};
            VMERdDone = 1;
          end
        end
      end
    end
    if (inj_done) begin VMERdDone = 1; VMEWrDone = 1; VMERdData = 32'hDEADBEEF; end
    if (noise && $urandom_range(7) == 0) begin
      VMERdData = $urandom;
      case ($urandom_range(3))
        0: VMERdDone  = 1;
        1: VMEWrDone  = 1;
        2: VMERdError = 1;
        default: VMEWrError = 1;
      endcase
    end
  end

  // ---------------- transaction-level expectation model ----------------
  // Cycle c of acceptance => strobe at c+1, completion window c+2 .. c+1+TIMEOUT,
  // response from the cycle after the outcome until the handshake.
  bit                m_open = 0, m_wr = 0, chk_en = 0;
  int                m_acc = 0, m_rsp_at = -1;
  logic [1:0]        m_st = '0;
  logic [DATA_W-1:0] m_rd = '0, m_wd = '0;
  logic [ADDR_HI:2]  m_addr = '0;

  always @(negedge Clk) begin
    bit e_busy, e_rv, e_strb, d_m, e_m;
    if (!rst_n) begin
      m_open = 0; m_rsp_at = -1; m_addr = '0; m_wd = '0; m_wr = 0;
    end else if (chk_en) begin
      e_busy = m_open && (cyc > m_acc);
      e_rv   = m_open && (m_rsp_at >= 0) && (cyc >= m_rsp_at);
      e_strb = m_open && (cyc == m_acc + 1);
      chk("cmd_ready", cmd_ready, !e_busy);
      chk("busy", busy, e_busy);
      chk("VMERdMem", VMERdMem, e_strb && !m_wr);
      chk("VMEWrMem", VMEWrMem, e_strb && m_wr);
      chk("rsp_valid", rsp_valid, e_rv);
      if (e_rv) begin
        chk("rsp_status", rsp_status, m_st);
        chk("rsp_rdata", rsp_rdata, m_rd);
      end
      chk("VMEAddr", VMEAddr, m_addr);
      chk("VMEWrData", VMEWrData, m_wd);
      if (m_open && m_rsp_at < 0 && cyc >= m_acc + 2) begin
        d_m = m_wr ? VMEWrDone  : VMERdDone;
        e_m = m_wr ? VMEWrError : VMERdError;
        if (e_m) begin
          m_st = ST_BUSERR; m_rd = '0; m_rsp_at = cyc + 1;
        end else if (d_m) begin
          m_st = ST_OK; m_rd = m_wr ? '0 : VMERdData; m_rsp_at = cyc + 1;
        end else if (cyc == m_acc + 1 + TIMEOUT) begin
          m_st = ST_TIMEOUT; m_rd = '0; m_rsp_at = cyc + 1;
        end
      end
      if (e_rv && rsp_ready) m_open = 0;
      else if (!e_busy && cmd_valid) begin
        m_open = 1; m_acc = cyc; m_rsp_at = -1; m_wr = cmd_write; m_addr = cmd_addr;
        if (cmd_write) m_wd = cmd_wdata;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_cmd(input bit w, input int a, input logic [31:0] d, input int stall,
                        output logic [1:0] st, output logic [31:0] rd, output int lat);
    int n, t0;
    @(posedge Clk); #2;
    cmd_valid = 1; cmd_write = w; cmd_addr = a[ADDR_HI-2:0]; cmd_wdata = d;
    rsp_ready = (stall == 0);
    n = 0;
    @(negedge Clk);
    while (!cmd_ready && n < 50) begin @(negedge Clk); n++; end
    if (!cmd_ready) bound_fail("cmd_accept");
    t0 = cyc;
    @(posedge Clk); #2;
    cmd_valid = 0;
    n = 0;
    @(negedge Clk);
    while (!rsp_valid && n < 100) begin @(negedge Clk); n++; end
    if (!rsp_valid) bound_fail("rsp_wait");
    lat = cyc - t0; st = rsp_status; rd = rsp_rdata;
    repeat (stall) @(posedge Clk);
    #2 rsp_ready = 1;
    @(posedge Clk); #2;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_status"}, rsp_status, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_VMEAddr"}, VMEAddr, 0);
    chk({tag, "_VMEWrData"}, VMEWrData, 0);
    chk({tag, "_VMERdMem"}, VMERdMem, 0);
    chk({tag, "_VMEWrMem"}, VMEWrMem, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  st;
    logic [31:0] rd;
    int lat, wr0, rd0, n;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1;
    #2 rst_n = 0;
    #1 chk_reset("reset");
    repeat (3) @(posedge Clk);
    #2 rst_n = 1;
    chk_en = 1;

    // write/read r1, read latency
    do_cmd(1, 0, 32'h000000A5, 0, st, rd, lat);
    chk("t1_wr_status", st, ST_OK);
    chk("t1_wr_rdata", rd, 0);
    do_cmd(0, 0, 32'h0, 0, st, rd, lat);
    chk("t1_rd_rdata", rd, 32'h000000A5);
    chk("t1_rd_status", st, ST_OK);
    chk("t1_rd_latency", lat, 3);

    // r2 is 16 bits wide; one strobe of each kind
    wr0 = n_wrp; rd0 = n_rdp;
    do_cmd(1, 1, 32'hFFFF1234, 0, st, rd, lat);
    do_cmd(0, 1, 32'h0, 0, st, rd, lat);
    chk("t2_rd_rdata", rd, 32'h00001234);
    chk("t2_wr_pulses", n_wrp - wr0, 1);
    chk("t2_rd_pulses", n_rdp - rd0, 1);

    // timeout, late completion ignored, recovery
    b_mode = 1;
    do_cmd(0, 5, 32'h0, 0, st, rd, lat);
    chk("t3_status", st, ST_TIMEOUT);
    chk("t3_rdata", rd, 0);
    chk("t3_latency", lat, TIMEOUT + 2);
    @(posedge Clk); #2 inj_done = 1;
    @(posedge Clk); #2 inj_done = 0;
    repeat (3) begin @(negedge Clk); chk("t3_late_done_ignored", rsp_valid, 0); end
    b_mode = 0;
    do_cmd(0, 0, 32'h0, 0, st, rd, lat);
    chk("t3_recover_rdata", rd, 32'h000000A5);
    chk("t3_recover_status", st, ST_OK);

    // bus error with Done in the same cycle
    b_mode = 2;
    do_cmd(1, 0, 32'h00000077, 0, st, rd, lat);
    chk("t4_wr_status", st, ST_BUSERR);
    chk("t4_wr_rdata", rd, 0);
    do_cmd(0, 1, 32'h0, 0, st, rd, lat);
    chk("t4_rd_status", st, ST_BUSERR);
    chk("t4_rd_rdata", rd, 0);
    b_mode = 0;

    // backpressure with the next command already waiting
    @(posedge Clk); #2;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 1; rsp_ready = 0;
    @(negedge Clk); chk("t5_ready_before", cmd_ready, 1);
    @(posedge Clk); #2;
    cmd_write = 1; cmd_addr = 0; cmd_wdata = 32'h0000005A;
    n = 0;
    @(negedge Clk);
    while (!rsp_valid && n < 50) begin @(negedge Clk); n++; end
    if (!rsp_valid) bound_fail("t5_rsp_wait");
    repeat (10) begin
      @(negedge Clk);
      chk("t5_hold_valid", rsp_valid, 1);
      chk("t5_hold_rdata", rsp_rdata, 32'h00001234);
      chk("t5_hold_status", rsp_status, ST_OK);
      chk("t5_hold_ready", cmd_ready, 0);
    end
    @(posedge Clk); #2 rsp_ready = 1;
    @(negedge Clk);
    @(negedge Clk); chk("t5_ready_after", cmd_ready, 1);
    @(posedge Clk); #2 cmd_valid = 0;
    @(negedge Clk); chk("t5_next_strobe", VMEWrMem, 1);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge Clk); n++; end
    if (!rsp_valid) bound_fail("t5_wr_rsp_wait");
    @(posedge Clk); #2;
    do_cmd(0, 0, 32'h0, 0, st, rd, lat);
    chk("t5_readback", rd, 32'h0000005A);

    // asynchronous reset during WAIT
    b_lat = 3;
    @(posedge Clk); #2;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 0;
    @(negedge Clk); chk("t6_ready", cmd_ready, 1);
    @(posedge Clk); #2 cmd_valid = 0;
    @(negedge Clk); chk("t6_strobe", VMERdMem, 1);
    @(posedge Clk); #3 rst_n = 0;
    #1 chk_reset("t6_reset");
    @(posedge Clk); #3 rst_n = 1;
    repeat (5) begin @(negedge Clk); chk("t6_no_rsp", rsp_valid, 0); end
    b_lat = 1;
    do_cmd(0, 0, 32'h0, 0, st, rd, lat);
    chk("t6_after_rdata", rd, 32'h0000005A);
    chk("t6_after_latency", lat, 3);

    // randomized traffic with spurious completions; model checks every cycle
    noise = 1;
    for (int i = 0; i < 250; i++) begin
      n = $urandom_range(9);
      b_mode = (n == 0) ? 1 : (n == 1) ? 2 : 0;
      b_lat = $urandom_range(1, 10);
      repeat ($urandom_range(2)) @(posedge Clk);
      do_cmd($urandom_range(1), $urandom_range(3), $urandom, $urandom_range(3), st, rd, lat);
    end
    noise = 0;
    repeat (5) @(posedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
